sfu_psum_accum: RTL and testbench
=================================

Name: sfu_psum_accum

Overview:
- Special-function stage directly upstream of the 128b x 16 output/psum SRAM; owns all of that SRAM's read and write ports.
- Consumes 8-lane x 16b partial-sum beats from the OFIFO, one beat per nij.
- Accumulates each beat into the SRAM entry at that nij across num_kij kernel passes, using read-modify-write.
- On the last pass, optionally applies ReLU before the final write.

Parameters:
- psum_bw, 16, width of one signed psum lane
- col, 8, lanes per beat; beat width = col*psum_bw = 128
- num_nij, 16, beats per pass; SRAM depth; address width = 4
- num_kij, 9, passes per layer

Ports:
- CLK  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a layer; ignored unless IDLE
- relu_en  in  1  sampled on accepted start; applies ReLU on the last pass
- in_valid  in  1  OFIFO beat available
- in_data  in  128  lane i = bits [16i+15:16i], signed
- in_ready  out  1  beat accepted when in_valid & in_ready
- sram_ren  out  1  SRAM read enable
- sram_r_A  out  4  SRAM read address
- sram_wen  out  1  SRAM write enable
- sram_w_A  out  4  SRAM write address
- sram_D  out  128  SRAM write data
- sram_Q  in  128  SRAM read data; valid the cycle after a read is issued
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (asynchronous, immediate) clears all outputs to 0, clears the FSM to IDLE and zeroes the counters. SRAM contents are untouched.
- FSM states: IDLE -> ACCUM on start; ACCUM -> DRAIN when the last beat is accepted (nij=num_nij-1, kij=num_kij-1); DRAIN -> DONE after 1 cycle; DONE -> IDLE after 1 cycle, with done=1 only in DONE.
- in_ready = (state==ACCUM). There is no combinational path from in_valid to in_ready.
- Counters: nij increments on each accepted beat and wraps num_nij-1 -> 0. kij increments on each nij wrap.
- Accept cycle T, with kij>0: sram_ren=1 and sram_r_A=nij. in_data, nij, first-pass flag and last-pass flag are registered into stage 1.
- Accept cycle T, with kij==0: no read is issued (sram_ren=0).
- Cycle T+1: sram_wen=1 and sram_w_A=stage-1 nij.
  - First pass: sram_D = stage-1 data (overwrite, so no SRAM clear is needed).
  - Later passes: sram_D = sat(sram_Q + stage-1 data), computed per lane.
- Fixed latency: exactly one write per accepted beat, always 1 cycle after acceptance. Back-to-back beats give 1 write/cycle.
- Arithmetic: per-lane signed 16b add with 17b intermediate, saturated to [-32768, 32767]. No carry crosses lanes.
- ReLU: on the last pass with relu_en latched, lanes < 0 are written as 0. Applied after saturation.
- Gaps (in_valid=0): no ren, and no wen on the following cycle. Stage 1 stays idle.
- Simultaneous read/write of the same address cannot occur inside a pass (nij values are distinct). The SRAM's registered read address returns post-write data, so no forwarding is required.
- When num_kij=1, every beat is both first and last: it is overwritten, then ReLU is applied if enabled.
- start while busy or in DONE: ignored, with no counter or relu_en change.
- Reset mid-operation: any pending stage-1 write is dropped. The next start restarts at kij=0, nij=0, and the first pass overwrites stale entries.

Decomposition:
- Shared package holds:
  - constants PSUM_BW, COL, NUM_NIJ, NUM_KIJ;
  - FSM state enum {IDLE, ACCUM, DRAIN, DONE};
  - lane slice helper.
- One sub-module: sfu_lane_addsat. It is combinational per lane, taking psum_bw a, b, first, relu and producing the psum_bw result. It is instantiated col times.

Test Plan:
- Nominal accumulation: start, relu_en=0, 9 passes x 16 beats, all lanes = 0x0001 -> every SRAM entry, every lane = 0x0009; done pulses once, 1 cycle after the final write.
- ReLU on: lane 0 = 0xFFFF each pass, relu_en=1 -> final lane 0 = 0x0000. Same stimulus with relu_en=0 -> final 0xFFF7.
- Saturation:
  - lane values 0x7000 over 2 passes (num_kij=2) -> 0x7FFF;
  - 0x8000 then 0xFFFF -> 0x8000;
  - other lanes unaffected.
- Backpressure/gaps: in_valid randomly deasserted ~50% -> results identical to nominal. ren is seen only on accepted beats with kij>0; wen is seen exactly 1 cycle after each accepted beat.
- Reset mid-op: assert reset_n=0 at kij=3, nij=7 -> in_ready, sram_wen, sram_ren, busy go 0 immediately. A restart with all-1 beats yields 0x0009 everywhere (stale data overwritten).
- start pulse during ACCUM with relu_en toggled -> ignored; the counters and latched relu_en are unchanged, and the final values match nominal.

Source files
------------

// File: rtl/sfu_psum_accum_pkg.sv
// Shared constants, FSM state type and lane helper for the psum
// accumulation stage and its per-lane add/saturate datapath.
package sfu_psum_accum_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int NUM_NIJ = 16;
    localparam int NUM_KIJ = 9;
    localparam int NIJ_W   = 4;
    localparam int KIJ_W   = 4;
    localparam int BEAT_W  = COL * PSUM_BW;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_e;

    // Lane idx of a beat: bits [idx*PSUM_BW +: PSUM_BW].
    function automatic logic [PSUM_BW-1:0] lane_slice(
        input logic [BEAT_W-1:0] beat,
        input int unsigned       idx
    );
        return beat[idx*PSUM_BW +: PSUM_BW];
    endfunction

endpackage

// File: rtl/sfu_lane_addsat.sv
// One psum lane: overwrite on the first pass, else signed saturating add;
// optional ReLU after saturation. Ports: a (new psum), b (SRAM psum),
// first, relu, y (lane result). Purely combinational.
module sfu_lane_addsat
    import sfu_psum_accum_pkg::*;
(
    input  logic [PSUM_BW-1:0] a,
    input  logic [PSUM_BW-1:0] b,
    input  logic               first,
    input  logic               relu,
    output logic [PSUM_BW-1:0] y
);

    logic [PSUM_BW:0]   sum;
    logic [PSUM_BW-1:0] sat;

    always_comb begin
        if (first) begin
            sum = {a[PSUM_BW-1], a};
        end else begin
            sum = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        end
        // Top two bits disagree only on signed overflow.
        if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
            sat = sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                               : {1'b0, {(PSUM_BW-1){1'b1}}};
        end else begin
            sat = sum[PSUM_BW-1:0];
        end
        if (relu && sat[PSUM_BW-1]) begin
            y = '0;
        end else begin
            y = sat;
        end
    end

endmodule

// File: rtl/sfu_psum_accum.sv
// Accumulates OFIFO psum beats into the output SRAM over NUM_KIJ passes
// via read-modify-write, with optional ReLU on the last pass.
// Ports: CLK/reset_n, start/relu_en control, in_valid/in_data/in_ready
// beat stream, sram_ren/r_A/wen/w_A/D/Q SRAM side, busy/done status.
module sfu_psum_accum
    import sfu_psum_accum_pkg::*;
(
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    input  logic              relu_en,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              in_ready,
    output logic              sram_ren,
    output logic [NIJ_W-1:0]  sram_r_A,
    output logic              sram_wen,
    output logic [NIJ_W-1:0]  sram_w_A,
    output logic [BEAT_W-1:0] sram_D,
    input  logic [BEAT_W-1:0] sram_Q,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [NIJ_W-1:0]  nij_q, nij_d;
    logic [KIJ_W-1:0]  kij_q, kij_d;
    logic              relu_q, relu_d;

    // Stage 1: beat accepted last cycle, written this cycle.
    logic              s1_valid_q, s1_valid_d;
    logic [BEAT_W-1:0] s1_data_q, s1_data_d;
    logic [NIJ_W-1:0]  s1_nij_q, s1_nij_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_relu_q, s1_relu_d;

    logic              accept;
    logic              first_pass;
    logic              last_pass;
    logic [BEAT_W-1:0] lane_y;

    assign in_ready   = (state_q == ACCUM);
    assign accept     = in_valid & in_ready;
    assign first_pass = (kij_q == '0);
    assign last_pass  = (kij_q == KIJ_W'(NUM_KIJ - 1));

    always_comb begin
        state_d    = state_q;
        nij_d      = nij_q;
        kij_d      = kij_q;
        relu_d     = relu_q;
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        s1_nij_d   = s1_nij_q;
        s1_first_d = s1_first_q;
        s1_relu_d  = s1_relu_q;

        if (accept) begin
            s1_data_d  = in_data;
            s1_nij_d   = nij_q;
            s1_first_d = first_pass;
            s1_relu_d  = last_pass & relu_q;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    nij_d   = '0;
                    kij_d   = '0;
                    relu_d  = relu_en;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (nij_q == NIJ_W'(NUM_NIJ - 1)) begin
                        nij_d = '0;
                        if (last_pass) begin
                            kij_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            kij_d = kij_q + 1'b1;
                        end
                    end else begin
                        nij_d = nij_q + 1'b1;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            nij_q      <= '0;
            kij_q      <= '0;
            relu_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_nij_q   <= '0;
            s1_first_q <= 1'b0;
            s1_relu_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nij_q      <= nij_d;
            kij_q      <= kij_d;
            relu_q     <= relu_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_nij_q   <= s1_nij_d;
            s1_first_q <= s1_first_d;
            s1_relu_q  <= s1_relu_d;
        end
    end

    for (genvar i = 0; i < COL; i++) begin : g_lane
        sfu_lane_addsat u_lane (
            .a     (lane_slice(s1_data_q, i)),
            .b     (lane_slice(sram_Q, i)),
            .first (s1_first_q),
            .relu  (s1_relu_q),
            .y     (lane_y[i*PSUM_BW +: PSUM_BW])
        );
    end

    // The first pass needs no read: its write overwrites the entry.
    assign sram_ren = accept & ~first_pass;
    assign sram_r_A = sram_ren ? nij_q : '0;
    assign sram_wen = s1_valid_q;
    assign sram_w_A = s1_nij_q;
    assign sram_D   = s1_valid_q ? lane_y : '0;
    assign busy     = (state_q == ACCUM) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sfu_psum_accum.sv
// Self-checking bench for sfu_psum_accum: SRAM model, reference
// accumulator model, directed and randomized layers.
module tb_sfu_psum_accum;

    localparam int NN = 16;
    localparam int NK = 9;

    logic         CLK = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         relu_en = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         sram_ren;
    logic [3:0]   sram_r_A;
    logic         sram_wen;
    logic [3:0]   sram_w_A;
    logic [127:0] sram_D;
    logic [127:0] sram_Q;
    logic         busy;
    logic         done;

    always #5 CLK = ~CLK;

    sfu_psum_accum dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .start    (start),
        .relu_en  (relu_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sram_ren (sram_ren),
        .sram_r_A (sram_r_A),
        .sram_wen (sram_wen),
        .sram_w_A (sram_w_A),
        .sram_D   (sram_D),
        .sram_Q   (sram_Q),
        .busy     (busy),
        .done     (done)
    );

    // SRAM model: registered read address, so reads see post-write data.
    logic [127:0] mem [NN];
    logic [3:0]   raddr = '0;
    always @(posedge CLK) begin
        if (sram_wen) mem[sram_w_A] <= sram_D;
        if (sram_ren) raddr <= sram_r_A;
    end
    assign sram_Q = mem[raddr];

    int n_assert = 0;
    int n_fail = 0;

    // Reference model state.
    logic [127:0] refmem [NN];
    int           phase = 0;  // 0 idle, 1 accum, 2 drain, 3 done
    int           m_nij = 0;
    int           m_kij = 0;
    bit           m_relu = 0;
    bit           pend_v = 0;
    int           pend_nij = 0;
    logic [127:0] pend_data = '0;
    bit           pend_first = 0;
    bit           pend_rl = 0;
    int           done_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_write(input logic [127:0] old,
        input logic [127:0] d, input bit first, input bit rl);
        logic [127:0] r;
        int a, b, s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            a = int'($signed(d[i*16 +: 16]));
            b = int'($signed(old[i*16 +: 16]));
            s = first ? a : a + b;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (rl && s < 0) s = 0;
            r[i*16 +: 16] = s[15:0];
        end
        return r;
    endfunction

    // One clock cycle: drive, check pre-edge, advance model.
    task automatic tick(input logic st, input logic rl, input logic v,
                        input logic [127:0] d);
        logic [127:0] wval;
        bit acc;
        start = st;
        relu_en = rl;
        in_valid = v;
        in_data = d;
        #1;
        acc = v && (phase == 1);
        chk("in_ready", 128'(in_ready), 128'(phase == 1));
        chk("ren", 128'(sram_ren), 128'(acc && m_kij > 0));
        if (acc && m_kij > 0) chk("r_A", 128'(sram_r_A), 128'(m_nij));
        chk("wen", 128'(sram_wen), 128'(pend_v));
        wval = '0;
        if (pend_v) begin
            wval = exp_write(refmem[pend_nij], pend_data, pend_first, pend_rl);
            chk("w_A", 128'(sram_w_A), 128'(pend_nij));
            chk("D", sram_D, wval);
        end
        chk("busy", 128'(busy), 128'(phase == 1 || phase == 2));
        chk("done", 128'(done), 128'(phase == 3));
        if (done) done_cnt++;
        @(posedge CLK);
        if (pend_v) refmem[pend_nij] = wval;
        pend_v = acc;
        if (acc) begin
            pend_nij = m_nij;
            pend_data = d;
            pend_first = (m_kij == 0);
            pend_rl = m_relu && (m_kij == NK - 1);
        end
        case (phase)
            0: if (st) begin
                phase = 1; m_nij = 0; m_kij = 0; m_relu = rl;
            end
            1: if (acc) begin
                m_nij++;
                if (m_nij == NN) begin
                    m_nij = 0;
                    m_kij++;
                    if (m_kij == NK) begin
                        m_kij = 0;
                        phase = 2;
                    end
                end
            end
            2: phase = 3;
            default: phase = 0;
        endcase
        @(negedge CLK);
    endtask

    function automatic logic [127:0] gen(input int mode);
        logic [127:0] d;
        d = {8{16'h0001}};
        case (mode)
            1: d[15:0] = 16'hFFFF;
            2: begin
                d[15:0] = 16'h7000;
                d[31:16] = (m_kij == 0) ? 16'h8000 : 16'hFFFF;
            end
            3: d = {$urandom, $urandom, $urandom, $urandom};
            default: ;
        endcase
        return d;
    endfunction

    task automatic run_layer(input int mode, input bit rl, input int gap,
                             input bit mid_start);
        int cyc;
        bit v;
        done_cnt = 0;
        tick(1'b1, rl, 1'b0, '0);
        cyc = 0;
        while (phase != 0 && cyc < 3000) begin
            v = (phase == 1) && ($urandom_range(99) >= gap);
            tick(mid_start && cyc == 37, mid_start ? !rl : rl, v, gen(mode));
            cyc++;
        end
        chk("layer_timeout", 128'(cyc < 3000), 128'(1));
        chk("done_once", 128'(done_cnt), 128'(1));
    endtask

    task automatic check_mem(input string tag, input bit use_c,
                             input logic [127:0] c);
        for (int n = 0; n < NN; n++) begin
            chk({tag, "_model"}, mem[n], refmem[n]);
            if (use_c) chk({tag, "_const"}, mem[n], c);
        end
    endtask

    initial begin
        for (int n = 0; n < NN; n++) begin
            mem[n] = '0;
            refmem[n] = '0;
        end
        @(negedge CLK);
        #1;
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_ren", 128'(sram_ren), 128'(0));
        chk("rst_wen", 128'(sram_wen), 128'(0));
        chk("rst_D", sram_D, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        @(negedge CLK);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0);

        run_layer(0, 1'b0, 0, 1'b0);
        check_mem("nominal", 1'b1, {8{16'h0009}});

        run_layer(1, 1'b1, 0, 1'b0);
        check_mem("relu_on", 1'b1, {{7{16'h0009}}, 16'h0000});

        run_layer(1, 1'b0, 0, 1'b0);
        check_mem("relu_off", 1'b1, {{7{16'h0009}}, 16'hFFF7});

        run_layer(2, 1'b0, 0, 1'b0);
        check_mem("sat", 1'b1, {{6{16'h0009}}, 16'h8000, 16'h7FFF});

        run_layer(0, 1'b0, 50, 1'b0);
        check_mem("gaps", 1'b1, {8{16'h0009}});

        run_layer(3, 1'($urandom_range(1)), 40, 1'b0);
        check_mem("random", 1'b0, '0);

        run_layer(1, 1'b0, 20, 1'b1);
        check_mem("mid_start", 1'b1, {{7{16'h0009}}, 16'hFFF7});

        // Reset mid-operation at kij=3, nij=7.
        tick(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3000 && !(m_kij == 3 && m_nij == 7); c++)
            tick(1'b0, 1'b0, 1'b1, gen(0));
        chk("mid_pos", 128'(m_kij * 16 + m_nij), 128'(3 * 16 + 7));
        chk("mid_wen_hi", 128'(sram_wen), 128'(1));
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_ready", 128'(in_ready), 128'(0));
        chk("mid_wen", 128'(sram_wen), 128'(0));
        chk("mid_ren", 128'(sram_ren), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        phase = 0; m_nij = 0; m_kij = 0; m_relu = 0; pend_v = 0;
        in_valid = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0);
        run_layer(0, 1'b0, 0, 1'b0);
        check_mem("restart", 1'b1, {8{16'h0009}});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
